fa_share_arb: RTL and testbench
===============================

Name: fa_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one W-bit full-adder datapath among NREQ requesters.
- Each requester presents operands a, b and a carry-in. The block grants one requester, latches its operands and computes sum/carry.
- It returns the result with the winner's ID over a valid/ready interface.
- Sits between multiple adder clients and the single adder instance.

Parameters:
- W, 2, operand and sum width in bits (>=1).
- NREQ, 4, number of requesters (>=2).
- IDW, $clog2(NREQ), width of requester ID (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request, level; held until matching gnt bit seen.
- op_a  input  NREQ*W  flattened operand A, requester i at [i*W +: W].
- op_b  input  NREQ*W  flattened operand B, same packing.
- op_cin  input  NREQ  per-requester carry-in.
- gnt  output  NREQ  one-hot grant pulse, registered, exactly one cycle per transaction.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_sum  output  W  sum bits.
- res_carry  output  1  carry-out.
- res_id  output  IDW  index of requester owning the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; gnt=0, res_valid=0, res_sum=0, res_carry=0, res_id=0, busy=0; rr pointer=0; operand latches=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If req != 0, pick the winner: first set bit scanning upward from pointer, wrapping NREQ-1 -> 0.
  - At the next edge: latch the winner's op_a/op_b/op_cin and winner ID; gnt[winner]=1; pointer = (winner+1) mod NREQ; go to CALC.
  - If req == 0, stay in IDLE; gnt=0.
- CALC:
  - gnt returns to 0 at the next edge.
  - At the next edge: {res_carry,res_sum} = latched a + b + cin, computed at W+1 bits with no truncation of the carry; res_id = winner; res_valid=1; go to RESP.
- RESP:
  - res_valid, res_sum, res_carry and res_id hold stable while res_ready=0.
  - On an edge with res_valid && res_ready: res_valid=0 and go to IDLE. res_sum/carry/id keep their last values.
- Latency:
  - req sampled in cycle T; gnt high in cycle T+1; res_valid high in cycle T+2.
  - Minimum spacing between successive grants is 3 cycles; there is no overlap of transactions.
- req is sampled only in IDLE. Requests raised during CALC/RESP wait. A requester dropping req before grant is simply not considered.
- A requester must deassert req in the cycle after seeing its gnt, otherwise it is re-granted when its turn comes again.
- Boundaries:
  - Max operands (all ones, cin=1) give sum=all ones, carry=1.
  - Pointer wraps from NREQ-1 to 0.
  - Single requester repeatedly requesting is granted every transaction.
- res_ready high in IDLE/CALC has no effect.
- Reset asserted mid-transaction (CALC or RESP) aborts it: outputs return to reset values immediately and the result is lost.

Optional Feature:
- Macro FA_ARB_FIXED_PRIO_EN.
- When defined: fixed priority. The lowest-index asserted req always wins and the pointer is unused (held at 0).
- When undefined: round-robin as described above.
- All other timing is identical in both modes.

Test Plan:
1. Reset: rst_n low 3 cycles with random req -> gnt=0, res_valid=0, res_sum=0, res_carry=0, busy=0 throughout.
2. Single req[2]=1, op_a[2]=2'b01, op_b[2]=2'b11, cin=1 (W=2):
   - gnt=4'b0100 one cycle later.
   - res_valid two cycles after sampling, with res_sum=2'b01, res_carry=1, res_id=2.
3. req=4'b1111 held, re-raised after each grant, res_ready=1:
   - Grant order 0,1,2,3,0, spaced exactly 3 cycles apart.
   - With FA_ARB_FIXED_PRIO_EN, grant order is 0,0,0.
4. Backpressure: res_ready=0 for 5 cycles after res_valid, req[1]=1 pending:
   - res_valid/res_sum/res_id stable, gnt stays 0.
   - res_ready=1 -> res_valid drops next edge, gnt[1] two cycles later.
5. Async reset asserted in RESP with res_valid=1 -> res_valid drops without a clock edge; after release with req=0, state is IDLE and busy=0.
6. Max values a=2'b11, b=2'b11, cin=1 -> res_sum=2'b11, res_carry=1; a=0, b=0, cin=0 -> sum 0, carry 0.

Source files
------------

// File: rtl/fa_share_arb.sv
// fa_share_arb: shares one W-bit full adder among NREQ requesters (round-robin).
// Define FA_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead.
module fa_share_arb #(
    parameter int  W    = 2,
    parameter int  NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    input  logic [NREQ-1:0]   op_cin,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_carry,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_sum_q, res_sum_d;
    logic            res_carry_q, res_carry_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW:0]    cand;
    logic [IDW:0]    nxt_ptr;
    logic [W:0]      sum_full;

    // Scan upward from the pointer with wrap; fixed priority keeps ptr_q at 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!win_found && req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        nxt_ptr = {1'b0, win_idx} + (IDW+1)'(1);
        if (nxt_ptr == (IDW+1)'(NREQ)) begin
            nxt_ptr = '0;
        end
    end

    assign sum_full = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath logic
    always_comb begin
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        win_d       = win_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_carry_d = res_carry_q;
        res_id_d    = res_id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d   = op_a[int'(win_idx)*W +: W];
                    b_d   = op_b[int'(win_idx)*W +: W];
                    cin_d = op_cin[win_idx];
                    win_d = win_idx;
                    gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
`ifdef FA_ARB_FIXED_PRIO_EN
                    ptr_d = '0;
`else
                    ptr_d = nxt_ptr[IDW-1:0];
`endif
                end
            end
            CALC: begin
                res_sum_d   = sum_full[W-1:0];
                res_carry_d = sum_full[W];
                res_id_d    = win_q;
                res_valid_d = 1'b1;
            end
            RESP: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            win_q       <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_carry_q <= res_carry_d;
            res_id_q    <= res_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_carry = res_carry_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fa_share_arb.sv
// Testbench for fa_share_arb: scenario tasks against a transaction-level model.
// Works with or without FA_ARB_FIXED_PRIO_EN defined.
module tb_fa_share_arb;

    localparam int W    = 2;
    localparam int NREQ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic [3:0] op_cin = '0;
    logic [3:0] gnt;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [1:0] res_sum;
    logic       res_carry;
    logic [1:0] res_id;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mptr  = 0;

    fa_share_arb #(.W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference arbitration: first asserted request at or after the pointer.
    function automatic int model_pick(input logic [3:0] r, input int p);
        int base;
        int j;
        base = p;
`ifdef FA_ARB_FIXED_PRIO_EN
        base = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            j = (base + k) % NREQ;
            if (((r >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    function automatic int model_sum(input int idx);
        int a;
        int b;
        int c;
        a = int'((op_a >> (idx * W)) & 8'h3);
        b = int'((op_b >> (idx * W)) & 8'h3);
        c = int'((op_cin >> idx) & 4'h1);
        return a + b + c;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    // Drives one transaction from a single requester and captures outputs.
    task automatic run_txn(input int idx, input logic [1:0] a,
                           input logic [1:0] b, input logic c,
                           output logic [3:0] g, output logic v,
                           output logic [1:0] s, output logic co,
                           output logic [1:0] id);
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        op_cin = 4'($urandom);
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
        op_cin[idx] = c;
        req = 4'b1 << idx;
        res_ready = 1'b0;
        tick();
        g = gnt;
        req = '0;
        tick();
        v = res_valid;
        s = res_sum;
        co = res_carry;
        id = res_id;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        mptr = (idx + 1) % NREQ;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom);
            res_ready = 1'($urandom);
            tick();
            total += 5;
            if (gnt !== 4'b0) begin
                bad++;
                $display("FAIL reset_gnt: got %b want 0000", gnt);
            end
            if (res_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid: got %b want 0", res_valid);
            end
            if (res_sum !== 2'b0) begin
                bad++;
                $display("FAIL reset_sum: got %b want 00", res_sum);
            end
            if (res_carry !== 1'b0) begin
                bad++;
                $display("FAIL reset_carry: got %b want 0", res_carry);
            end
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy: got %b want 0", busy);
            end
        end
        req = '0;
        res_ready = 1'b0;
        rst_n = 1'b1;
        mptr = 0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] g;
        logic v, co;
        logic [1:0] s, id;
        do_reset();
        run_txn(2, 2'b01, 2'b11, 1'b1, g, v, s, co, id);
        total += 5;
        if (g !== 4'b0100) begin
            bad++;
            $display("FAIL single_gnt: got %b want 0100", g);
        end
        if (v !== 1'b1) begin
            bad++;
            $display("FAIL single_valid: got %b want 1", v);
        end
        if (s !== 2'b01) begin
            bad++;
            $display("FAIL single_sum: got %b want 01", s);
        end
        if (co !== 1'b1) begin
            bad++;
            $display("FAIL single_carry: got %b want 1", co);
        end
        if (id !== 2'd2) begin
            bad++;
            $display("FAIL single_id: got %0d want 2", id);
        end
    endtask

    task automatic test_round_robin();
        int ng;
        int last;
        int exp;
        do_reset();
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        op_cin = 4'($urandom);
        req = 4'hF;
        res_ready = 1'b1;
        ng = 0;
        last = 0;
        for (int c = 0; c < 30 && ng < 5; c++) begin
            tick();
            if (gnt !== 4'b0) begin
                exp = model_pick(req, mptr);
                total++;
                if (gnt !== (4'b1 << exp)) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: got %b want %b",
                             ng, gnt, 4'b1 << exp);
                end
                mptr = (exp + 1) % NREQ;
                if (ng > 0) begin
                    total++;
                    if (cyc - last != 3) begin
                        bad++;
                        $display("FAIL rr_spacing[%0d]: got %0d want 3",
                                 ng, cyc - last);
                    end
                end
                last = cyc;
                ng++;
            end
        end
        total++;
        if (ng < 5) begin
            bad++;
            $display("FAIL rr_count: got %0d grants want 5", ng);
        end
        req = '0;
        tick();
        tick();
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [1:0] s0, id0;
        int exp;
        do_reset();
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        op_cin = 4'($urandom);
        req = 4'b0001;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL bp_gnt0: got %b want 0001", gnt);
        end
        mptr = 1;
        req = 4'b0010;
        tick();
        exp = model_sum(0);
        total += 2;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_valid: got %b want 1", res_valid);
        end
        if ({res_carry, res_sum} !== 3'(exp)) begin
            bad++;
            $display("FAIL bp_sum: got %0d want %0d",
                     {res_carry, res_sum}, exp);
        end
        s0 = res_sum;
        id0 = res_id;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_sum !== s0 ||
                res_id !== id0 || gnt !== 4'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%b id=%0d g=%b want v=1 s=%b id=%0d g=0000",
                         i, res_valid, res_sum, res_id, gnt, s0, id0);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total += 2;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drop: got %b want 0", res_valid);
        end
        if (gnt !== 4'b0) begin
            bad++;
            $display("FAIL bp_gnt_early: got %b want 0000", gnt);
        end
        tick();
        exp = model_pick(4'b0010, mptr);
        total++;
        if (gnt !== (4'b1 << exp)) begin
            bad++;
            $display("FAIL bp_gnt1: got %b want %b", gnt, 4'b1 << exp);
        end
        mptr = (exp + 1) % NREQ;
        req = '0;
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        op_a = 8'hFF;
        op_b = 8'hFF;
        op_cin = 4'hF;
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL ar_pre_valid: got %b want 1", res_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_valid: got %b want 0", res_valid);
        end
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ar_busy: got %b want 0", busy);
        end
        if (res_sum !== 2'b0 || res_carry !== 1'b0) begin
            bad++;
            $display("FAIL ar_sum: got %b%b want 000", res_carry, res_sum);
        end
        tick();
        rst_n = 1'b1;
        mptr = 0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL ar_idle: got busy=%b v=%b g=%b want 0 0 0000",
                     busy, res_valid, gnt);
        end
    endtask

    task automatic test_max_values();
        logic [3:0] g;
        logic v, co;
        logic [1:0] s, id;
        run_txn(1, 2'b11, 2'b11, 1'b1, g, v, s, co, id);
        total += 2;
        if ({co, s} !== 3'b111) begin
            bad++;
            $display("FAIL max_sum: got %b want 111", {co, s});
        end
        if (id !== 2'd1) begin
            bad++;
            $display("FAIL max_id: got %0d want 1", id);
        end
        run_txn(3, 2'b00, 2'b00, 1'b0, g, v, s, co, id);
        total += 2;
        if ({co, s} !== 3'b000) begin
            bad++;
            $display("FAIL zero_sum: got %b want 000", {co, s});
        end
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL zero_gnt: got %b want 1000", g);
        end
    endtask

    task automatic test_random();
        int w;
        int exp;
        int stall;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            op_cin = 4'($urandom);
            req = 4'($urandom_range(1, 15));
            res_ready = 1'b0;
            tick();
            w = model_pick(req, mptr);
            total++;
            if (gnt !== (4'b1 << w)) begin
                bad++;
                $display("FAIL rand_gnt[%0d]: got %b want %b",
                         n, gnt, 4'b1 << w);
            end
            mptr = (w + 1) % NREQ;
            exp = model_sum(w);
            req = '0;
            tick();
            total++;
            if (res_valid !== 1'b1 || {res_carry, res_sum} !== 3'(exp) ||
                res_id !== 2'(w) || gnt !== 4'b0) begin
                bad++;
                $display("FAIL rand_res[%0d]: got v=%b sum=%0d id=%0d want v=1 sum=%0d id=%0d",
                         n, res_valid, {res_carry, res_sum}, res_id, exp, w);
            end
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                tick();
                total++;
                if (res_valid !== 1'b1 || gnt !== 4'b0) begin
                    bad++;
                    $display("FAIL rand_stall[%0d]: got v=%b g=%b want 1 0000",
                             n, res_valid, gnt);
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rand_done[%0d]: got v=%b busy=%b want 0 0",
                         n, res_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        test_max_values();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
